// File: rtl/control_pkg.sv
// Shared encodings for the control unit: instruction kinds, FSM states,
// instruction field positions and the decoded-field bundle.
package control_pkg;

   typedef enum logic [1:0] {
      KIND_ALU   = 2'b00,
      KIND_LOAD  = 2'b01,
      KIND_STORE = 2'b10,
      KIND_CONST = 2'b11
   } kind_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_CFETCH = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam int KIND_HI   = 31;
   localparam int KIND_LO   = 30;
   localparam int ALU_OP_HI = 29;
   localparam int ALU_OP_LO = 27;
   localparam int FORM_BIT  = 26;
   localparam int VEC_HI    = 25;
   localparam int VEC_LO    = 24;
   localparam int WRITE_HI  = 23;
   localparam int WRITE_LO  = 22;
   localparam int Y1_HI     = 21;
   localparam int Y1_LO     = 18;
   localparam int Y2_HI     = 17;
   localparam int Y2_LO     = 14;
   localparam int A_HI      = 13;
   localparam int A_LO      = 10;
   localparam int B_HI      = 9;
   localparam int B_LO      = 6;
   localparam int C_HI      = 5;
   localparam int C_LO      = 2;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [2:0]  LD_PASS   = 3'b110;
   localparam logic [1:0]  WRITE_LD  = 2'b01;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       form;
      logic [1:0] vec;
      logic [1:0] write;
      logic [3:0] y1;
      logic [3:0] y2;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
   } instr_fields_t;

endpackage

// File: rtl/control_unit_if.sv
// Memory request/acknowledge bus between the control unit and memory.
interface control_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: kind, HALT detection and field extraction.
module instr_decoder
   import control_pkg::*;
(
   input  logic [31:0]   instr,
   output kind_e         kind,
   output logic          is_halt,
   output instr_fields_t fields
);

   logic unused_low_bits;
   assign unused_low_bits = ^instr[1:0];

   // Field slicing and kind/halt classification
   always_comb begin
      kind          = kind_e'(instr[KIND_HI:KIND_LO]);
      is_halt       = (instr == HALT_WORD);
      fields.alu_op = instr[ALU_OP_HI:ALU_OP_LO];
      fields.form   = instr[FORM_BIT];
      fields.vec    = instr[VEC_HI:VEC_LO];
      fields.write  = instr[WRITE_HI:WRITE_LO];
      fields.y1     = instr[Y1_HI:Y1_LO];
      fields.y2     = instr[Y2_HI:Y2_LO];
      fields.a      = instr[A_HI:A_LO];
      fields.b      = instr[B_HI:B_LO];
      fields.c      = instr[C_HI:C_LO];
   end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches words over the memory bus, decodes them and
// drives datapath control for ALU, LOAD, STORE, CONST and HALT.
module control_unit
   import control_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   control_unit_if.master       mem,
   input  logic [31:0]          program_counter,
   input  logic [31:0]          mem_loca,
   input  logic [31:0]          st_data,
   output logic [2:0]           alu_op,
   output logic                 form,
   output logic [1:0]           vec,
   output logic [1:0]           write,
   output logic [3:0]           A,
   output logic [3:0]           B,
   output logic [3:0]           C,
   output logic [3:0]           D,
   output logic [3:0]           Y1,
   output logic [3:0]           Y2,
   output logic [3:0]           logic_select,
   output logic [3:0]           mem_loca_addr,
   output logic                 const_c,
   output logic                 pc_inc,
   output logic [31:0]          constant,
   output logic [31:0]          ld_data,
   output logic                 halted
);

   state_e        state_q, state_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   constant_q, constant_d;
   logic [31:0]   ld_data_q, ld_data_d;
   logic          halted_q, halted_d;

   logic [31:0]   dec_word;
   kind_e         dec_kind;
   logic          dec_halt;
   instr_fields_t dec_f;

   // While fetching, classify the word on the bus so the ack cycle can branch.
   assign dec_word = (state_q == ST_FETCH) ? mem.mem_rdata : instr_q;

   instr_decoder u_dec (
      .instr   (dec_word),
      .kind    (dec_kind),
      .is_halt (dec_halt),
      .fields  (dec_f)
   );

   // State and latched-data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         instr_q    <= 32'd0;
         constant_q <= 32'd0;
         ld_data_q  <= 32'd0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         constant_q <= constant_d;
         ld_data_q  <= ld_data_d;
         halted_q   <= halted_d;
      end
   end

   // Next-state and output decode; reset forces every output to idle at once
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      constant_d    = constant_q;
      ld_data_d     = ld_data_q;
      halted_d      = halted_q;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = 32'd0;
      mem.mem_wdata = 32'd0;
      alu_op        = 3'd0;
      form          = 1'b0;
      vec           = 2'd0;
      write         = 2'd0;
      A             = 4'd0;
      B             = 4'd0;
      C             = 4'd0;
      D             = 4'd0;
      Y1            = 4'd0;
      Y2            = 4'd0;
      logic_select  = 4'd0;
      mem_loca_addr = 4'd0;
      const_c       = 1'b0;
      pc_inc        = 1'b0;
      constant      = 32'd0;
      ld_data       = 32'd0;
      halted        = 1'b0;
      if (rst) begin
         state_d = ST_FETCH;
      end else begin
         constant = constant_q;
         ld_data  = ld_data_q;
         halted   = halted_q;
         case (state_q)
            ST_FETCH: begin
               mem.mem_req  = 1'b1;
               mem.mem_addr = program_counter;
               if (mem.mem_ack) begin
                  instr_d = mem.mem_rdata;
                  if (dec_halt) begin
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                  end else begin
                     case (dec_kind)
                        KIND_CONST: state_d = ST_CFETCH;
                        KIND_LOAD:  state_d = ST_MEM;
                        KIND_STORE: state_d = ST_MEM;
                        KIND_ALU:   state_d = ST_EXEC;
                        default:    state_d = ST_EXEC;
                     endcase
                  end
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_CFETCH: begin
               mem.mem_req  = 1'b1;
               mem.mem_addr = program_counter + 32'd1;
               if (mem.mem_ack) begin
                  constant_d = mem.mem_rdata;
                  pc_inc     = 1'b1;
                  state_d    = ST_EXEC;
               end else begin
                  state_d = ST_CFETCH;
               end
            end
            ST_EXEC: begin
               alu_op       = dec_f.alu_op;
               form         = dec_f.form;
               vec          = dec_f.vec;
               write        = dec_f.write;
               Y1           = dec_f.y1;
               Y2           = dec_f.y2;
               A            = dec_f.a;
               B            = dec_f.b;
               C            = dec_f.c;
               D            = dec_f.y2;
               logic_select = dec_f.c;
               const_c      = (dec_kind == KIND_CONST);
               pc_inc       = 1'b1;
               state_d      = ST_FETCH;
            end
            ST_MEM: begin
               mem_loca_addr = dec_f.a;
               B             = dec_f.b;
               mem.mem_req   = 1'b1;
               mem.mem_addr  = mem_loca;
               if (dec_kind == KIND_STORE) begin
                  mem.mem_we    = 1'b1;
                  mem.mem_wdata = st_data;
                  if (mem.mem_ack) begin
                     pc_inc  = 1'b1;
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_MEM;
                  end
               end else begin
                  if (mem.mem_ack) begin
                     ld_data_d = mem.mem_rdata;
                     state_d   = ST_WB;
                  end else begin
                     state_d = ST_MEM;
                  end
               end
            end
            ST_WB: begin
               alu_op  = LD_PASS;
               Y1      = dec_f.y1;
               write   = WRITE_LD;
               pc_inc  = 1'b1;
               state_d = ST_FETCH;
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench: acts as memory and PC datapath, predicting
// each instruction's bus phases and control outputs from the encoding rules.
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc, mem_loca, st_data;
   logic [2:0]  alu_op;
   logic        form, const_c, pc_inc, halted;
   logic [1:0]  vec, write;
   logic [3:0]  a_s, b_s, c_s, d_s, y1_s, y2_s, lsel_s, mla_s;
   logic [31:0] constant, ld_data;
   logic [31:0] exp_const, exp_ld;
   int          n_checks, n_pass;

   control_unit_if bus ();

   control_unit dut (
      .clk(clk), .rst(rst), .mem(bus.master),
      .program_counter(pc), .mem_loca(mem_loca), .st_data(st_data),
      .alu_op(alu_op), .form(form), .vec(vec), .write(write),
      .A(a_s), .B(b_s), .C(c_s), .D(d_s), .Y1(y1_s), .Y2(y2_s),
      .logic_select(lsel_s), .mem_loca_addr(mla_s),
      .const_c(const_c), .pc_inc(pc_inc),
      .constant(constant), .ld_data(ld_data), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] fld(input logic [31:0] w, input int lo, input int width);
      return (w >> lo) & ((32'd1 << width) - 32'd1);
   endfunction

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic chk_idle(input string tag);
      check_eq({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
      check_eq({tag, "_write"}, {30'd0, write}, 32'd0);
      check_eq({tag, "_pcinc"}, {31'd0, pc_inc}, 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk_idle(tag);
      check_eq({tag, "_constc"}, {31'd0, const_c}, 32'd0);
      check_eq({tag, "_halted"}, {31'd0, halted}, 32'd0);
      check_eq({tag, "_const"}, constant, 32'd0);
      check_eq({tag, "_ld"}, ld_data, 32'd0);
   endtask

   // One bus transaction of waits+1 cycles; ack arrives in the last cycle.
   task automatic mem_phase(input string tag, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                            input logic inc_on_ack, input logic chk_regs, input logic [31:0] word);
      for (int i = 0; i <= waits; i++) begin
         bus.mem_ack   = (i == waits);
         bus.mem_rdata = (i == waits) ? rdata : $urandom();
         @(negedge clk);
         check_eq({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
         check_eq({tag, "_addr"}, bus.mem_addr, addr);
         check_eq({tag, "_we"}, {31'd0, bus.mem_we}, {31'd0, we});
         if (we) check_eq({tag, "_wdata"}, bus.mem_wdata, wdata);
         check_eq({tag, "_write"}, {30'd0, write}, 32'd0);
         check_eq({tag, "_pcinc"}, {31'd0, pc_inc}, (inc_on_ack && i == waits) ? 32'd1 : 32'd0);
         if (chk_regs) begin
            check_eq({tag, "_mla"}, {28'd0, mla_s}, fld(word, 10, 4));
            check_eq({tag, "_b"}, {28'd0, b_s}, fld(word, 6, 4));
         end
         next_cycle();
         if (inc_on_ack && i == waits) pc = pc + 32'd1;
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic exec_phase(input logic [31:0] word, input logic is_const);
      bus.mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("exec_req", {31'd0, bus.mem_req}, 32'd0);
      check_eq("exec_aluop", {29'd0, alu_op}, fld(word, 27, 3));
      check_eq("exec_form", {31'd0, form}, fld(word, 26, 1));
      check_eq("exec_vec", {30'd0, vec}, fld(word, 24, 2));
      check_eq("exec_write", {30'd0, write}, fld(word, 22, 2));
      check_eq("exec_y1", {28'd0, y1_s}, fld(word, 18, 4));
      check_eq("exec_y2", {28'd0, y2_s}, fld(word, 14, 4));
      check_eq("exec_d", {28'd0, d_s}, fld(word, 14, 4));
      check_eq("exec_a", {28'd0, a_s}, fld(word, 10, 4));
      check_eq("exec_b", {28'd0, b_s}, fld(word, 6, 4));
      check_eq("exec_c", {28'd0, c_s}, fld(word, 2, 4));
      check_eq("exec_lsel", {28'd0, lsel_s}, fld(word, 2, 4));
      check_eq("exec_constc", {31'd0, const_c}, {31'd0, is_const});
      check_eq("exec_pcinc", {31'd0, pc_inc}, 32'd1);
      check_eq("exec_const", constant, exp_const);
      next_cycle();
      pc = pc + 32'd1;
      bus.mem_ack = 1'b0;
   endtask

   task automatic wb_phase(input logic [31:0] word);
      bus.mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("wb_req", {31'd0, bus.mem_req}, 32'd0);
      check_eq("wb_aluop", {29'd0, alu_op}, 32'd6);
      check_eq("wb_y1", {28'd0, y1_s}, fld(word, 18, 4));
      check_eq("wb_write", {30'd0, write}, 32'd1);
      check_eq("wb_pcinc", {31'd0, pc_inc}, 32'd1);
      check_eq("wb_ld", ld_data, exp_ld);
      next_cycle();
      pc = pc + 32'd1;
      bus.mem_ack = 1'b0;
   endtask

   // Whole instruction: fetch, then the phases its kind calls for.
   task automatic run_instr(input logic [31:0] word, input int wf, input int w2,
                            input logic [31:0] data, input logic [31:0] loca, input logic [31:0] sdata);
      mem_loca = loca;
      st_data  = sdata;
      mem_phase("fetch", pc, 1'b0, 32'd0, wf, word, 1'b0, 1'b0, word);
      case (word >> 30)
         32'd0: exec_phase(word, 1'b0);
         32'd3: begin
            mem_phase("cfetch", pc + 32'd1, 1'b0, 32'd0, w2, data, 1'b1, 1'b0, word);
            exp_const = data;
            exec_phase(word, 1'b1);
         end
         32'd1: begin
            mem_phase("load", loca, 1'b0, 32'd0, w2, data, 1'b0, 1'b1, word);
            exp_ld = data;
            wb_phase(word);
         end
         default: mem_phase("store", loca, 1'b1, sdata, w2, $urandom(), 1'b1, 1'b1, word);
      endcase
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         bus.mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_reset("reset");
         next_cycle();
      end
      rst         = 1'b0;
      bus.mem_ack = 1'b0;
      exp_const   = 32'd0;
      exp_ld      = 32'd0;
   endtask

   initial begin
      logic [31:0] w;
      n_checks = 0; n_pass = 0;
      rst = 1'b1; pc = 32'h40; mem_loca = 32'd0; st_data = 32'd0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
      exp_const = 32'd0; exp_ld = 32'd0;
      next_cycle();
      do_reset(2);

      run_instr(32'h0A48_4D28, 0, 0, 32'd0, 32'd0, 32'd0);
      check_eq("alu_next_pc", pc, 32'h41);
      run_instr(32'hC000_0000 | 32'h0123_4567, 0, 2, 32'hDEAD_BEEF, 32'd0, 32'd0);
      check_eq("const_pc", pc, 32'h43);
      run_instr(32'h4000_0000 | 32'h0055_5AA8, 0, 0, 32'h1234_5678, 32'h100, 32'd0);
      run_instr(32'h8000_0000 | 32'h0AAA_0550, 0, 0, 32'd0, 32'h200, 32'hCAFE_0001);
      pc = 32'hFFFF_FFFF;
      run_instr(32'hC800_0000, 1, 0, 32'h0000_5A5A, 32'd0, 32'd0);
      check_eq("wrap_pc", pc, 32'd1);

      for (int n = 0; n < 40; n++) begin
         w = $urandom();
         if (w == 32'hFFFF_FFFF) w = 32'hFFFF_FFFE;
         run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), $urandom(), $urandom(), $urandom());
      end

      // Reset while a LOAD waits for its ack; stray ack must not land.
      mem_loca = 32'h300;
      mem_phase("fetch", pc, 1'b0, 32'd0, 0, 32'h4000_1234, 1'b0, 1'b0, 32'h4000_1234);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("midrst");
      next_cycle();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
      @(negedge clk);
      chk_reset("midrst_stray");
      next_cycle();
      rst = 1'b0; bus.mem_ack = 1'b0; exp_const = 32'd0; exp_ld = 32'd0;
      run_instr(32'h0A48_4D28, 0, 0, 32'd0, 32'd0, 32'd0);

      mem_phase("fetch", pc, 1'b0, 32'd0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
      for (int i = 0; i < 20; i++) begin
         bus.mem_ack = 1'($urandom_range(0, 1)); bus.mem_rdata = $urandom();
         @(negedge clk);
         chk_idle("halt");
         check_eq("halt_flag", {31'd0, halted}, 32'd1);
         next_cycle();
      end
      do_reset(1);
      run_instr(32'h3000_0000 | 32'h00F0_F0F0, 0, 0, 32'd0, 32'd0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
